// File: rtl/backend_profile_sequencer_pkg.sv
// Shared state encoding and backend config map for the profile sequencer.
// Pure definitions: no logic, no latency, no flow control.
package backend_profile_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_RUN
   } seq_state_t;

   localparam int CFG_WORDS = 10;

   localparam logic [5:0] CCR0_LO     = 6'h00;
   localparam logic [5:0] CCR0_HI     = 6'h01;
   localparam logic [5:0] CCR1_LO     = 6'h02;
   localparam logic [5:0] CCR1_HI     = 6'h03;
   localparam logic [5:0] ORD_CMPL_LO = 6'h04;
   localparam logic [5:0] ORD_CMPL_HI = 6'h05;
   localparam logic [5:0] ROW_LIMIT   = 6'h06;
   localparam logic [5:0] COL_LIMIT   = 6'h07;
   localparam logic [5:0] INV_SEL     = 6'h08;
   localparam logic [5:0] ROW_COL_SEL = 6'h09;

   // Profile words map contiguously onto the backend config space from CCR0_LO.
   function automatic logic [5:0] cfg_addr(input logic [3:0] word);
      return CCR0_LO + {2'b00, word};
   endfunction

endpackage

// File: rtl/backend_profile_sequencer_shadow_store.sv
// Shadow store of N_PROFILES x 10 config words; synchronous write, combinational read.
// Write lands on the next edge; read is same-cycle; no backpressure (caller gates writes).
module backend_profile_sequencer_shadow_store
   import backend_profile_sequencer_pkg::*;
#(
   parameter int N_PROFILES   = 4,
   parameter int PROFILE_BITS = 2
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    write_enable,
   input  logic [PROFILE_BITS-1:0] write_profile,
   input  logic [3:0]              write_word,
   input  logic [15:0]             write_data,
   input  logic [PROFILE_BITS-1:0] read_profile,
   input  logic [3:0]              read_word,
   output logic [15:0]             read_data
);

   logic [15:0] mem [N_PROFILES][CFG_WORDS];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < N_PROFILES; p++) begin
            for (int w = 0; w < CFG_WORDS; w++) begin
               mem[p][w] <= '0;
            end
         end
      end else if (write_enable && (32'(write_word) < CFG_WORDS)
                   && (32'(write_profile) < N_PROFILES)) begin
         mem[write_profile][write_word] <= write_data;
      end
   end

   // Out-of-range indices read as zero (the load path looks one word past the end).
   always_comb begin
      read_data = '0;
      if ((32'(read_word) < CFG_WORDS) && (32'(read_profile) < N_PROFILES)) begin
         read_data = mem[read_profile][read_word];
      end
   end

endmodule

// File: rtl/backend_profile_sequencer.sv
// Bursts stored profiles into the backend, runs its timer until completion, then advances.
// First config write 1 cycle after start; host writes while busy are dropped with host_reject.
module backend_profile_sequencer
   import backend_profile_sequencer_pkg::*;
#(
   parameter int N_PROFILES    = 4,
   parameter int PROFILE_BITS  = 2,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    host_write_n,
   input  logic [PROFILE_BITS-1:0] host_profile,
   input  logic [3:0]              host_address,
   input  logic [15:0]             host_data,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    loop_enable,
   input  logic [PROFILE_BITS-1:0] last_profile,
   input  logic                    update_cycle_complete,
   output logic                    write_config_n,
   output logic [5:0]              config_address,
   output logic [15:0]             config_data,
   output logic                    timer_enable,
   output logic                    busy,
   output logic [PROFILE_BITS-1:0] active_profile,
   output logic                    profile_done,
   output logic                    sequence_done,
   output logic                    host_reject
);

   localparam logic [PROFILE_BITS-1:0] MAX_PROFILE = PROFILE_BITS'(N_PROFILES - 1);
   localparam logic [3:0]              LAST_WORD   = 4'(CFG_WORDS - 1);

   seq_state_t              state;
   logic [3:0]              word;
   logic [7:0]              settle_cnt;
   logic                    stop_latch;
   logic [PROFILE_BITS-1:0] eff_last;

   logic                    host_valid;
   logic                    shadow_we;
   logic [PROFILE_BITS-1:0] next_profile;
   logic [PROFILE_BITS-1:0] rd_profile;
   logic [3:0]              rd_word;
   logic [15:0]             rd_data;
   logic                    finish;

   assign host_valid   = !host_write_n && (host_address <= LAST_WORD);
   assign shadow_we    = host_valid && (state == ST_IDLE);
   assign next_profile = (active_profile == eff_last) ? '0 : active_profile + 1'b1;
   assign finish       = stop_latch || stop || ((active_profile == eff_last) && !loop_enable);

   // Read port is aimed at the word that will be presented on the next edge.
   always_comb begin
      rd_profile = active_profile;
      rd_word    = word + 4'd1;
      if (state == ST_IDLE) begin
         rd_profile = '0;
         rd_word    = '0;
      end else if (state == ST_RUN) begin
         rd_profile = next_profile;
         rd_word    = '0;
      end
   end

   backend_profile_sequencer_shadow_store #(
      .N_PROFILES   (N_PROFILES),
      .PROFILE_BITS (PROFILE_BITS)
   ) u_shadow (
      .clock         (clock),
      .reset_n       (reset_n),
      .write_enable  (shadow_we),
      .write_profile (host_profile),
      .write_word    (host_address),
      .write_data    (host_data),
      .read_profile  (rd_profile),
      .read_word     (rd_word),
      .read_data     (rd_data)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         word           <= '0;
         settle_cnt     <= '0;
         stop_latch     <= 1'b0;
         eff_last       <= '0;
         write_config_n <= 1'b1;
         config_address <= '0;
         config_data    <= '0;
         timer_enable   <= 1'b0;
         busy           <= 1'b0;
         active_profile <= '0;
         profile_done   <= 1'b0;
         sequence_done  <= 1'b0;
         host_reject    <= 1'b0;
      end else begin
         profile_done  <= 1'b0;
         sequence_done <= 1'b0;
         host_reject   <= host_valid && (state != ST_IDLE);
         if (stop && (state != ST_IDLE)) begin
            stop_latch <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (start && host_write_n) begin
                  state          <= ST_LOAD;
                  busy           <= 1'b1;
                  active_profile <= '0;
                  eff_last       <= (last_profile > MAX_PROFILE) ? MAX_PROFILE : last_profile;
                  word           <= '0;
                  write_config_n <= 1'b0;
                  config_address <= cfg_addr(4'd0);
                  config_data    <= rd_data;
               end
            end

            ST_LOAD: begin
               if (word == LAST_WORD) begin
                  write_config_n <= 1'b1;
                  timer_enable   <= 1'b1;
                  settle_cnt     <= '0;
                  state          <= ST_SETTLE;
               end else begin
                  word           <= word + 4'd1;
                  config_address <= cfg_addr(word + 4'd1);
                  config_data    <= rd_data;
               end
            end

            // Backend completion flag is stale while its ordering counter restarts.
            ST_SETTLE: begin
               if (32'(settle_cnt) + 32'd1 >= 32'(SETTLE_CYCLES)) begin
                  state <= ST_RUN;
               end else begin
                  settle_cnt <= settle_cnt + 8'd1;
               end
            end

            ST_RUN: begin
               if (update_cycle_complete) begin
                  timer_enable <= 1'b0;
                  profile_done <= 1'b1;
                  if (finish) begin
                     state         <= ST_IDLE;
                     busy          <= 1'b0;
                     sequence_done <= 1'b1;
                     stop_latch    <= 1'b0;
                  end else begin
                     state          <= ST_LOAD;
                     active_profile <= next_profile;
                     word           <= '0;
                     write_config_n <= 1'b0;
                     config_address <= cfg_addr(4'd0);
                     config_data    <= rd_data;
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_backend_profile_sequencer.sv
// Scoreboard bench: expected config writes are queued per profile and matched as the DUT emits them.
module tb_backend_profile_sequencer;

   localparam int PB = 2;

   logic          clock;
   logic          reset_n;
   logic          host_write_n;
   logic [PB-1:0] host_profile;
   logic [3:0]    host_address;
   logic [15:0]   host_data;
   logic          start;
   logic          stop;
   logic          loop_enable;
   logic [PB-1:0] last_profile;
   logic          update_cycle_complete;
   logic          write_config_n;
   logic [5:0]    config_address;
   logic [15:0]   config_data;
   logic          timer_enable;
   logic          busy;
   logic [PB-1:0] active_profile;
   logic          profile_done;
   logic          sequence_done;
   logic          host_reject;

   int checks = 0;
   int errors = 0;
   int pd_cnt = 0;
   int sd_cnt = 0;
   int pd0;
   int sd0;

   logic [15:0] model [4][10];
   logic [23:0] exp_q [$];
   logic [23:0] mon_e;

   backend_profile_sequencer #(
      .N_PROFILES    (4),
      .PROFILE_BITS  (PB),
      .SETTLE_CYCLES (2)
   ) dut (
      .clock                 (clock),
      .reset_n               (reset_n),
      .host_write_n          (host_write_n),
      .host_profile          (host_profile),
      .host_address          (host_address),
      .host_data             (host_data),
      .start                 (start),
      .stop                  (stop),
      .loop_enable           (loop_enable),
      .last_profile          (last_profile),
      .update_cycle_complete (update_cycle_complete),
      .write_config_n        (write_config_n),
      .config_address        (config_address),
      .config_data           (config_data),
      .timer_enable          (timer_enable),
      .busy                  (busy),
      .active_profile        (active_profile),
      .profile_done          (profile_done),
      .sequence_done         (sequence_done),
      .host_reject           (host_reject)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Every config write the DUT emits must match the head of the scoreboard.
   always @(negedge clock) begin
      if (write_config_n === 1'b0) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_write", exp_q.size(), 1);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("cfg_prof", 32'(active_profile), 32'(mon_e[23:22]));
            check_eq("cfg_addr", 32'(config_address), 32'(mon_e[21:16]));
            check_eq("cfg_data", 32'(config_data), 32'(mon_e[15:0]));
            check_eq("tmr_in_load", 32'(timer_enable), 0);
         end
      end
      if (profile_done === 1'b1) pd_cnt++;
      if (sequence_done === 1'b1) sd_cnt++;
   end

   task automatic push_profile(input int p);
      for (int k = 0; k < 10; k++) exp_q.push_back({2'(p), 6'(k), model[p][k]});
   endtask

   task automatic host_wr(input int p, input int a, input logic [15:0] d, input bit accept);
      host_profile = PB'(p);
      host_address = 4'(a);
      host_data    = d;
      host_write_n = 1'b0;
      @(negedge clock);
      host_write_n = 1'b1;
      if (accept && a <= 9) model[p][a] = d;
   endtask

   task automatic write_profile(input int p, input logic [15:0] base);
      for (int k = 0; k < 10; k++) host_wr(p, k, base + 16'(k), 1'b1);
   endtask

   task automatic kick();
      push_profile(0);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check_eq("first_write_n", 32'(write_config_n), 0);
      check_eq("busy_on_start", 32'(busy), 1);
   endtask

   task automatic wait_timer();
      for (int i = 0; i < 40 && timer_enable !== 1'b1; i++) @(negedge clock);
      check_eq("timer_rise", 32'(timer_enable), 1);
   endtask

   // Completion pulsed in RUN cycle 'delay'; next_p < 0 means the sequence should end.
   task automatic run_profile(input int delay, input int next_p);
      wait_timer();
      repeat (2) @(negedge clock);
      check_eq("run_timer_on", 32'(timer_enable), 1);
      repeat (delay - 1) @(negedge clock);
      if (next_p >= 0) push_profile(next_p);
      update_cycle_complete = 1'b1;
      @(negedge clock);
      update_cycle_complete = 1'b0;
      check_eq("profile_done", 32'(profile_done), 1);
      check_eq("timer_off", 32'(timer_enable), 0);
      check_eq("sequence_done", 32'(sequence_done), (next_p < 0) ? 1 : 0);
      check_eq("busy_after_run", 32'(busy), (next_p >= 0) ? 1 : 0);
      if (next_p >= 0) check_eq("next_profile", 32'(active_profile), 32'(next_p));
   endtask

   task automatic clear_model();
      for (int p = 0; p < 4; p++)
         for (int k = 0; k < 10; k++) model[p][k] = 16'h0000;
   endtask

   task automatic check_pulses(input string tag, input int pd_exp, input int sd_exp);
      repeat (2) @(negedge clock);
      #1;
      check_eq({tag, "_pd"}, pd_cnt - pd0, pd_exp);
      check_eq({tag, "_sd"}, sd_cnt - sd0, sd_exp);
   endtask

   initial begin
      reset_n = 1'b0;
      host_write_n = 1'b1;
      host_profile = '0;
      host_address = '0;
      host_data = '0;
      start = 1'b0;
      stop = 1'b0;
      loop_enable = 1'b0;
      last_profile = '0;
      update_cycle_complete = 1'b0;
      clear_model();
      repeat (2) @(negedge clock);
      check_eq("rst_write_n", 32'(write_config_n), 1);
      check_eq("rst_addr", 32'(config_address), 0);
      check_eq("rst_data", 32'(config_data), 0);
      check_eq("rst_timer", 32'(timer_enable), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_active", 32'(active_profile), 0);
      check_eq("rst_pulses", {29'd0, profile_done, sequence_done, host_reject}, 0);
      reset_n = 1'b1;
      @(negedge clock);

      // Single profile, completion in RUN cycle 5; out-of-range host write ignored.
      write_profile(0, 16'h1000);
      host_wr(0, 12, 16'hBEEF, 1'b0);
      check_eq("ignored_no_reject", 32'(host_reject), 0);
      pd0 = pd_cnt; sd0 = sd_cnt;
      kick();
      run_profile(5, -1);
      check_pulses("single", 1, 1);

      // Reset while word 4 is on the config port.
      kick();
      for (int i = 0; i < 20; i++) begin
         if (write_config_n === 1'b0 && config_address == 6'd4) break;
         @(negedge clock);
      end
      check_eq("saw_word4", 32'(config_address), 4);
      pd0 = pd_cnt; sd0 = sd_cnt;
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_write_n", 32'(write_config_n), 1);
      check_eq("mid_rst_timer", 32'(timer_enable), 0);
      check_eq("mid_rst_busy", 32'(busy), 0);
      exp_q.delete();
      clear_model();
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      check_pulses("mid_rst", 0, 0);

      // Three profiles, no loop; profile 2 left at its reset contents.
      write_profile(0, 16'h2000);
      write_profile(1, 16'hA5A0);
      last_profile = 2'd2;
      loop_enable = 1'b0;
      pd0 = pd_cnt; sd0 = sd_cnt;
      kick();
      run_profile(3, 1);
      run_profile(1, 2);
      run_profile(7, -1);
      check_pulses("three", 3, 1);

      // Looping over 0..1, stop raised during the second pass's profile 1 load.
      last_profile = 2'd1;
      loop_enable = 1'b1;
      pd0 = pd_cnt; sd0 = sd_cnt;
      kick();
      run_profile(2, 1);
      run_profile(2, 0);
      run_profile(2, 1);
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      check_eq("stop_no_truncate", 32'(write_config_n), 0);
      run_profile(2, -1);
      check_pulses("loop_stop", 4, 1);
      loop_enable = 1'b0;

      // Start coincident with a host write: write taken, start ignored.
      host_profile = 2'd0;
      host_address = 4'd5;
      host_data = 16'h5555;
      host_write_n = 1'b0;
      start = 1'b1;
      @(negedge clock);
      host_write_n = 1'b1;
      start = 1'b0;
      model[0][5] = 16'h5555;
      check_eq("start_blocked", 32'(busy), 0);

      // Completion held high: ignored through SETTLE, taken on first RUN cycle.
      last_profile = 2'd0;
      update_cycle_complete = 1'b1;
      kick();
      host_wr(0, 3, 16'hDEAD, 1'b0);
      check_eq("reject_pulse", 32'(host_reject), 1);
      @(negedge clock);
      check_eq("reject_one_cycle", 32'(host_reject), 0);
      wait_timer();
      check_eq("settle0_ignored", 32'(profile_done), 0);
      @(negedge clock);
      check_eq("settle1_ignored", 32'(profile_done), 0);
      @(negedge clock);
      check_eq("run0_pending", 32'(profile_done), 0);
      @(negedge clock);
      update_cycle_complete = 1'b0;
      check_eq("held_done", 32'(profile_done), 1);
      check_eq("held_seq_done", 32'(sequence_done), 1);
      check_eq("held_timer_off", 32'(timer_enable), 0);

      // Reload profile 0 to confirm the rejected write never landed.
      kick();
      run_profile(4, -1);
      repeat (3) @(negedge clock);
      check_eq("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
